// File: rtl/key_conditioner.sv
// key_conditioner: synchronises, debounces and edge-detects active-low pushbuttons.
// Optional per-key auto-repeat of press pulses when KEY_AUTOREPEAT_EN is defined.
module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] level,
    output logic [NUM_KEYS-1:0] press,
    output logic [NUM_KEYS-1:0] key_release
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("key_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        logic             r_sync1;
        logic             r_sync2;
        logic             r_level;
        logic             r_press;
        logic             r_release;
        logic [CNT_W-1:0] r_cnt;
        logic             w_cur;
        logic             w_differs;
        logic             w_flip;
        logic             w_repeat;

        assign w_cur     = ~r_sync2;
        assign w_differs = (w_cur != r_level);
        assign w_flip    = w_differs && (r_cnt == CNT_LAST);

`ifdef KEY_AUTOREPEAT_EN
        localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RPT_W   = $clog2(RPT_MAX + 1);
        localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
        localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
        localparam logic [RPT_W-1:0] RPT_ONE         = RPT_W'(1);

        logic [RPT_W-1:0] r_rpt_cnt;
        logic             r_rpt_armed;

        // A release flip wins over a repeat so press and release never coincide.
        assign w_repeat = r_level && !w_flip &&
                          (r_rpt_cnt == (r_rpt_armed ? RPT_PERIOD_LAST : RPT_DELAY_LAST));

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_rpt_cnt   <= '0;
                r_rpt_armed <= 1'b0;
            end else if (!r_level || w_flip) begin
                r_rpt_cnt   <= '0;
                r_rpt_armed <= 1'b0;
            end else if (w_repeat) begin
                r_rpt_cnt   <= '0;
                r_rpt_armed <= 1'b1;
            end else begin
                r_rpt_cnt   <= r_rpt_cnt + RPT_ONE;
            end
        end
`else
        assign w_repeat = 1'b0;
`endif

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                // NOTE: synchroniser resets to 1 (released) so leaving reset never looks like a press.
                r_sync1   <= 1'b1;
                r_sync2   <= 1'b1;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_cnt     <= '0;
            end else begin
                // NOTE: non-blocking, so r_sync2 takes the old r_sync1 and the two stages stay distinct.
                r_sync1   <= key_n[g];
                r_sync2   <= r_sync1;
                r_press   <= (w_flip && w_cur) || w_repeat;
                r_release <= w_flip && !w_cur;
                if (w_flip) begin
                    r_level <= w_cur;
                    r_cnt   <= '0;
                end else if (w_differs) begin
                    r_cnt   <= r_cnt + CNT_ONE;
                end else begin
                    r_cnt   <= '0;
                end
            end
        end

        assign level[g]       = r_level;
        assign press[g]       = r_press;
        assign key_release[g] = r_release;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: a windowed reference model predicts every cycle's
// outputs into a queue and an independent monitor pops and compares on the falling edge.
module tb_key_conditioner;

    localparam int NK = 4;
    localparam int DC = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    typedef struct packed {
        logic [NK-1:0] level;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
    } out_t;

    logic          clock;
    logic          reset;
    logic [NK-1:0] key_n;
    logic [NK-1:0] level;
    logic [NK-1:0] press;
    logic [NK-1:0] key_release;

    key_conditioner #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_n      (key_n),
        .level      (level),
        .press      (press),
        .key_release(key_release)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_press_cnt = 0;
    int   dut_press_cnt = 0;
    out_t exp_q[$];

    // Reference model state: raw sample history, seen-key history, level and hold time.
    logic [NK-1:0] m_samples[$];
    logic [NK-1:0] m_cur[$];
    logic [NK-1:0] m_level;
    int            m_held[NK];

    task automatic model_reset();
        m_samples.delete();
        m_cur.delete();
        for (int i = 0; i < 3; i++) m_samples.push_back('1);
        for (int i = 0; i < DC; i++) m_cur.push_back('0);
        m_level = '0;
        for (int k = 0; k < NK; k++) m_held[k] = 0;
    endtask

    // One clock edge with reset inactive; a key changes once its last DC observations all disagree.
    task automatic model_edge(input logic [NK-1:0] sample, output out_t o);
        logic [NK-1:0] cur;
        logic          all_diff;
        o = '0;
        m_samples.push_front(sample);
        while (m_samples.size() > 3) void'(m_samples.pop_back());
        cur = ~m_samples[2];
        m_cur.push_front(cur);
        while (m_cur.size() > DC) void'(m_cur.pop_back());
        for (int k = 0; k < NK; k++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DC; j++)
                if (m_cur[j][k] == m_level[k]) all_diff = 1'b0;
            if (all_diff) begin
                m_level[k] = cur[k];
                o.press[k] = cur[k];
                o.rel[k]   = ~cur[k];
                m_held[k]  = 0;
            end else if (m_level[k]) begin
                m_held[k]++;
`ifdef KEY_AUTOREPEAT_EN
                if (m_held[k] >= RD && (m_held[k] - RD) % RP == 0) o.press[k] = 1'b1;
`endif
            end
        end
        o.level = m_level;
        model_press_cnt += $countones(o.press);
    endtask

    // Model process: samples inputs at the edge, then accounts for any asynchronous reset.
    initial begin
        logic [NK-1:0] key_s;
        logic          rst_s;
        out_t          o;
        model_reset();
        forever begin
            @(posedge clock);
            key_s = key_n;
            rst_s = reset;
            #3;
            if (!rst_s || !reset) begin
                model_reset();
                o = '0;
            end else begin
                model_edge(key_s, o);
            end
            exp_q.push_back(o);
        end
    end

    // Monitor: compares DUT outputs with the oldest prediction away from the active edge.
    initial begin
        out_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                dut_press_cnt += $countones(press);
                if ({level, press, key_release} !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got level=%b press=%b release=%b, expected level=%b press=%b release=%b",
                             $time, level, press, key_release, e.level, e.press, e.rel);
                end
            end
        end
    end

    task automatic step(input logic [NK-1:0] kn, input logic rst);
        @(posedge clock);
        #2;
        key_n = kn;
        reset = rst;
    endtask

    task automatic hold(input logic [NK-1:0] kn, input int cycles);
        for (int i = 0; i < cycles; i++) step(kn, 1'b1);
    endtask

    initial begin
        int            hold_left[NK];
        logic [NK-1:0] kn;
        key_n = '1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step('1, 1'b0);
        hold('1, 6);

        // Single press and release on key 1.
        hold(4'b1101, 20);
        hold(4'b1111, 12);

        // Bounces on key 2 shorter than the debounce window.
        hold(4'b1011, 3);
        hold(4'b1111, 1);
        hold(4'b1011, 3);
        hold(4'b1111, 12);

        // Independent keys 0 and 3, staggered by two cycles.
        hold(4'b1110, 2);
        hold(4'b0110, 15);
        hold(4'b1111, 12);

        // Reset in the middle of a count with the key still held.
        hold(4'b1101, 3);
        step(4'b1101, 1'b0);
        step(4'b1101, 1'b0);
        hold(4'b1101, 15);
        hold(4'b1111, 12);

        // Long hold on key 2 (exercises auto-repeat when enabled).
        hold(4'b1011, 30);
        hold(4'b1111, 12);

        // Random mix of short bounces, long holds and occasional resets.
        kn = '1;
        for (int k = 0; k < NK; k++) hold_left[k] = $urandom_range(1, 10);
        for (int c = 0; c < 2500; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (hold_left[k] == 0) begin
                    kn[k] = ~kn[k];
                    hold_left[k] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 30);
                end else begin
                    hold_left[k]--;
                end
            end
            step(kn, ($urandom_range(0, 299) != 0));
        end
        hold('1, 12);

        @(negedge clock);
        @(negedge clock);
        #1;
        n_cmp++;
        if (dut_press_cnt != model_press_cnt) begin
            n_bad++;
            $display("FAIL press_count: got %0d pulses, expected %0d", dut_press_cnt, model_press_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
